word_drainer: RTL
=================

# word_drainer

Word-to-byte serializer for the instruction-memory load path: accepts 32-bit words over a valid/ready handshake, buffers them in a small FIFO, and emits each word as four bytes, most-significant byte first, over a byte-wide valid/ready stream. It is the transmit-side counterpart of the byte-to-word assembler. A word shifted out here and fed byte-by-byte into the assembler reproduces the original word. It sits between the word source (memory readback or debug dump) and the byte-wide UART/host link.

## Interface
- WORD_W, 32, input word width; must equal BYTES_PER_WORD*BYTE_W
- BYTE_W, 8, output byte width
- DEPTH, 2, word FIFO entries (power of two, ≥2)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; clears all state
- word_in  in  WORD_W  word to serialize
- word_valid  in  1  word_in valid
- word_ready  out  1  word accepted on edge where word_valid && word_ready
- byte_out  out  BYTE_W  current byte
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  byte consumed on edge where byte_valid && byte_ready
- busy  out  1  FIFO non-empty or serializer in SEND

## Operation
- Word FIFO: push on word handshake; word_ready = !full (combinational). A push attempt while full is not accepted, even if a pop occurs the same cycle.
- Serializer FSM, states IDLE and SEND; 32-bit shift register shreg; 2-bit byte counter cnt.
- byte_out = shreg[31:24] (registered; driven directly from shreg).
- IDLE transition: if FIFO non-empty, load shreg from FIFO head, pop, cnt<=0, byte_valid<=1, go to SEND. Otherwise remain in IDLE with byte_valid=0.
- SEND, no byte handshake: hold shreg, cnt and byte_valid. byte_out must stay stable while byte_valid && !byte_ready.
- SEND, byte handshake, cnt<3: shreg <= shreg<<8, cnt<=cnt+1.
- SEND, byte handshake, cnt==3, FIFO non-empty: load the next word, pop, cnt<=0, stay in SEND. No bubble between words.
- SEND, byte handshake, cnt==3, FIFO empty: byte_valid<=0, go to IDLE.
- busy = (state==SEND) || !empty.
- Reset, including mid-word: FIFO emptied, partial word discarded, state IDLE.

## Timing
- Reset values:
  - byte_out=0, byte_valid=0, busy=0, state=IDLE, cnt=0, FIFO empty.
  - word_ready=1, since the FIFO is empty. Pushes while rst is high are ignored.
- Latency, idle block: word accepted at edge E → byte_valid high after edge E+1 with the MSB byte.
- Throughput: one byte per cycle while byte_ready=1 and words are available. Sustained rate is one word per 4 cycles.
- Capacity under full backpressure: DEPTH words in the FIFO plus 1 in shreg. The (DEPTH+2)th word stalls.
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy is unchanged.
- cnt wraps 3→0 only on a word reload.

## Structure
- Package drainer_pkg holds:
  - localparam BYTES_PER_WORD=4
  - typedef enum logic {IDLE, SEND} drain_state_t
  - typedef logic [BYTE_W-1:0] byte_t
- Sub-module word_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, din, dout, full, empty
  - read and write pointers one bit wider than the address, for full/empty detection
  - dout = head entry, combinational read
- word_drainer instantiates word_fifo and contains the FSM and shift register.

## Test plan
- Single word: push 0xDEADBEEF with byte_ready=1 → byte_out DE, AD, BE, EF on 4 consecutive cycles, starting 2 edges after acceptance; then byte_valid=0 and busy=0.
- Back-to-back: push 0x01020304, 0x05060708, 0x090A0B0C on consecutive cycles with byte_ready=1 → 12 bytes 01…0C with no gap cycles.
- Backpressure: push 0xCAFEF00D, then hold byte_ready=0 for 3 cycles while byte_out=FE → byte_out stays FE with byte_valid=1; stream resumes with F0, 0D.
- Full: DEPTH=2, byte_ready=0, push 4 words → 3 accepted, word_ready=0 for the 4th. Releasing byte_ready drains all 12 bytes in order, and word_ready returns to 1 one cycle after the first FIFO pop.
- Reset mid-word: assert rst after byte AD of 0xDEADBEEF → byte_valid=0, busy=0, word_ready=1 immediately. A subsequent push of 0x11223344 emits 11, 22, 33, 44 with no residue from the aborted word.

Source files
------------

// File: rtl/drainer_pkg.sv
// ============================================================================
// drainer_pkg: shared types and constants for the word-to-byte drainer.
// Rev 1.0
// ============================================================================
`default_nettype none

package drainer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_BITS      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  typedef logic [BYTE_BITS-1:0] byte_t;

endpackage : drainer_pkg

`default_nettype wire

// File: rtl/word_fifo.sv
// ============================================================================
// word_fifo: power-of-two word FIFO, combinational head read, wrap-bit pointers.
// Rev 1.0
// ============================================================================
`default_nettype none

module word_fifo
  import drainer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Full when the pointers address the same slot but differ in the wrap bit.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout  = r_mem[r_rptr[AW-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule : word_fifo

`default_nettype wire

// File: rtl/word_drainer.sv
// ============================================================================
// word_drainer: buffers 32-bit words and streams them out MSB byte first.
// Rev 1.0
// ============================================================================
`default_nettype none

module word_drainer
  import drainer_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_byte_valid;
  logic              w_byte_valid_nxt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;

  assign w_push = word_valid && !w_full;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (word_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_byte_valid <= w_byte_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_cnt_nxt        = r_cnt;
    w_byte_valid_nxt = r_byte_valid;
    w_pop            = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_shreg_nxt      = w_head;
          w_pop            = 1'b1;
          w_cnt_nxt        = '0;
          w_byte_valid_nxt = 1'b1;
          w_state_nxt      = SEND;
        end
      end
      SEND: begin
        if (r_byte_valid && byte_ready) begin
          if (r_cnt != C_CNT_LAST) begin
            w_shreg_nxt = r_shreg << BYTE_W;
            w_cnt_nxt   = r_cnt + C_CNT_ONE;
          end else if (!w_empty) begin
            // Reload straight from the FIFO so consecutive words leave no gap.
            w_shreg_nxt = w_head;
            w_pop       = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_byte_valid_nxt = 1'b0;
            w_state_nxt      = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt      = IDLE;
        w_byte_valid_nxt = 1'b0;
      end
    endcase
  end

  assign word_ready = !w_full;
  assign byte_out   = r_shreg[WORD_W-1 -: BYTE_W];
  assign byte_valid = r_byte_valid;
  assign busy       = (r_state == SEND) || !w_empty;

endmodule : word_drainer

`default_nettype wire
